// File: rtl/i2c_pkg.sv
// i2c_pkg: shared state encoding and timing defaults for the I2C register arbiter
package i2c_pkg;
  typedef enum logic [2:0] {IDLE, PTR, DATA, STOP1, RD, STOP2, DONE, ERR_RST} state_t;
  localparam int STOP_CYC_DEF = 600;
  localparam int TIMEOUT_CYC_DEF = 100000;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-way round-robin grant; the last-granted index loses ties
module rr_arb2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       take,
  output logic [1:0] gnt,
  output logic       idx
);
  logic last;
  always_comb begin
    idx = req[1] & (~req[0] | ~last);
    gnt = req == 2'b00 ? 2'b00 : (idx ? 2'b10 : 2'b01);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) last <= 1'b1;
    else if (take && req != 2'b00) last <= idx;
endmodule

// File: rtl/i2c_reg_arbiter.sv
// i2c_reg_arbiter: shares one byte-level I2C master between two register read/write requesters
module i2c_reg_arbiter
  import i2c_pkg::*;
#(
  parameter int STOP_CYC    = STOP_CYC_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rq_valid,
  input  logic [1:0] rq_rd,
  input  logic [6:0] rq_dev0,
  input  logic [6:0] rq_dev1,
  input  logic [7:0] rq_reg0,
  input  logic [7:0] rq_reg1,
  input  logic [7:0] rq_wdata0,
  input  logic [7:0] rq_wdata1,
  output logic [1:0] rq_ack,
  output logic [1:0] rq_done,
  output logic       rq_err,
  output logic [7:0] rdata,
  output logic       m_ena,
  output logic       m_rd_wrt,
  output logic [6:0] m_addr,
  output logic [7:0] m_data_wrt,
  input  logic       m_busy,
  input  logic       m_err,
  input  logic [7:0] m_data_rd,
  output logic       m_rst
);
  localparam int CW = $clog2(max2(STOP_CYC, TIMEOUT_CYC) + 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_CYC - 1);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYC - 1);
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [1:0] gnt;
  logic gnt_idx, grant, busy_q, rd_q, err_q;
  logic [6:0] dev_q;
  logic [7:0] reg_q, wdata_q;
  logic fall, busy_edge, active, timed_out;
  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (rq_valid),
    .take  (state == IDLE),
    .gnt   (gnt),
    .idx   (gnt_idx)
  );
  assign fall = busy_q & ~m_busy;
  assign busy_edge = busy_q ^ m_busy;
  assign active = state inside {PTR, DATA, RD};
  assign timed_out = active && cnt >= TO_LAST;
  assign m_addr = dev_q;
  always_comb begin
    state_n = state;
    rq_ack = 2'b00;
    rq_done = 2'b00;
    rq_err = 1'b0;
    m_ena = 1'b0;
    m_rd_wrt = 1'b0;
    m_data_wrt = reg_q;
    case (state)
      IDLE: begin
        rq_ack = gnt;
        state_n = |gnt ? PTR : IDLE;
      end
      PTR: begin
        m_ena = 1'b1;
        if (fall) state_n = rd_q ? STOP1 : DATA;
      end
      DATA: begin
        m_ena = 1'b1;
        m_data_wrt = wdata_q;
        if (fall) state_n = STOP2;
      end
      STOP1: state_n = cnt == STOP_LAST ? RD : STOP1;
      RD: begin
        m_ena = 1'b1;
        m_rd_wrt = 1'b1;
        if (fall) state_n = STOP2;
      end
      STOP2: state_n = cnt == STOP_LAST ? DONE : STOP2;
      DONE: begin
        rq_done = grant ? 2'b10 : 2'b01;
        rq_err = err_q;
        state_n = IDLE;
      end
      default: state_n = cnt == CW'(1) ? DONE : ERR_RST;
    endcase
    if (timed_out) state_n = ERR_RST;
    // a master error overrides any byte completion seen in the same cycle
    if (m_err && state inside {PTR, DATA, STOP1, RD, STOP2}) begin
      m_ena = 1'b0;
      state_n = ERR_RST;
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      busy_q <= 1'b0;
      cnt <= '0;
      grant <= 1'b0;
      dev_q <= '0;
      reg_q <= '0;
      wdata_q <= '0;
      rd_q <= 1'b0;
      err_q <= 1'b0;
      rdata <= '0;
      m_rst <= 1'b1;
    end else begin
      state <= state_n;
      busy_q <= m_busy;
      m_rst <= state_n == ERR_RST;
      cnt <= (state_n != state || (active && busy_edge)) ? '0 : (cnt == CNT_MAX ? cnt : cnt + 1'b1);
      if (state == IDLE && |gnt) begin
        grant <= gnt_idx;
        dev_q <= gnt_idx ? rq_dev1 : rq_dev0;
        reg_q <= gnt_idx ? rq_reg1 : rq_reg0;
        wdata_q <= gnt_idx ? rq_wdata1 : rq_wdata0;
        rd_q <= rq_rd[gnt_idx];
        err_q <= 1'b0;
      end
      if (state_n == ERR_RST) err_q <= 1'b1;
      if (state == RD && fall && !m_err) rdata <= m_data_rd;
    end
endmodule

// File: tb/tb_i2c_reg_arbiter.sv
// tb_i2c_reg_arbiter: scoreboard bench with a behavioural byte-level master and slave model
module tb_i2c_reg_arbiter;
  localparam int STOP_CYC = 20;
  localparam int TIMEOUT_CYC = 1000;
  localparam int STOP_TOK = 256;
  typedef struct {bit rd; bit err; logic [7:0] rdata;} exp_t;
  logic clk = 0, reset = 1;
  logic [1:0] rq_valid, rq_rd = 0, rq_ack, rq_done;
  logic [6:0] rq_dev0 = 0, rq_dev1 = 0, m_addr;
  logic [7:0] rq_reg0 = 0, rq_reg1 = 0, rq_wdata0 = 0, rq_wdata1 = 0, rdata, m_data_wrt;
  logic [7:0] m_data_rd = 0, rd_val = 0;
  logic rq_err, m_ena, m_rd_wrt, m_rst, m_busy = 0, m_err = 0;
  exp_t exp_q0[$], exp_q1[$];
  int ack_exp[$], bus_exp[$];
  int issue_n[2] = '{0, 0}, ack_n[2] = '{0, 0};
  int checks = 0, failures = 0;
  int cyc = 0, busy_t = 0, rst_t = 0, bcnt = 0;
  bit bus_chk = 1, nack = 0, hang = 0;
  bit started = 0, cur_rd = 0, addr_ph = 0, mrst_q = 0;
  bit [1:0] outstanding = 0, drop = 0;
  assign rq_valid = {issue_n[1] != ack_n[1], issue_n[0] != ack_n[0]};
  i2c_reg_arbiter #(.STOP_CYC(STOP_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .reset(reset), .rq_valid(rq_valid), .rq_rd(rq_rd),
    .rq_dev0(rq_dev0), .rq_dev1(rq_dev1), .rq_reg0(rq_reg0), .rq_reg1(rq_reg1),
    .rq_wdata0(rq_wdata0), .rq_wdata1(rq_wdata1), .rq_ack(rq_ack), .rq_done(rq_done),
    .rq_err(rq_err), .rdata(rdata), .m_ena(m_ena), .m_rd_wrt(m_rd_wrt), .m_addr(m_addr),
    .m_data_wrt(m_data_wrt), .m_busy(m_busy), .m_err(m_err), .m_data_rd(m_data_rd), .m_rst(m_rst)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic log_byte(input int b);
    if (bus_chk) begin
      if (bus_exp.size() == 0) chk("bus_extra", b, -1);
      else chk("bus_byte", b, bus_exp.pop_front());
    end
  endtask
  // master/slave model: one busy pulse per command, address byte logged on a new START
  always @(negedge clk) begin
    cyc++;
    if (m_rst && !mrst_q) rst_t = cyc;
    mrst_q = m_rst;
    if (m_rst) begin
      m_busy = 0;
      m_err = 0;
      started = 0;
    end else if (m_busy) begin
      if (!hang) begin
        if (bcnt == 0) begin
          m_busy = 0;
          if (nack && addr_ph) m_err = 1;
          if (cur_rd) m_data_rd = rd_val;
        end else bcnt--;
      end
    end else if (m_ena && !m_err) begin
      addr_ph = !started || m_rd_wrt != cur_rd;
      if (addr_ph) log_byte({m_addr, m_rd_wrt});
      started = 1;
      cur_rd = m_rd_wrt;
      if (!m_rd_wrt) log_byte(m_data_wrt);
      m_busy = 1;
      bcnt = 3;
      busy_t = cyc;
    end else if (!m_ena && started) begin
      log_byte(STOP_TOK);
      started = 0;
    end
  end
  // requesters drop valid the cycle after ack; completions are checked against the scoreboard
  always @(negedge clk) begin
    exp_t e;
    for (int i = 0; i < 2; i++) if (drop[i]) begin
      ack_n[i]++;
      drop[i] = 0;
    end
    for (int i = 0; i < 2; i++) if (rq_ack[i]) begin
      drop[i] = 1;
      outstanding[i] = 1;
      if (ack_exp.size() != 0) chk("ack_order", i, ack_exp.pop_front());
    end
    for (int i = 0; i < 2; i++) if (rq_done[i]) begin
      chk("ack_before_done", outstanding[i], 1);
      outstanding[i] = 0;
      if ((i == 0 ? exp_q0.size() : exp_q1.size()) == 0) chk("done_unexpected", i, -1);
      else begin
        e = i == 0 ? exp_q0.pop_front() : exp_q1.pop_front();
        chk(i == 0 ? "done0_err" : "done1_err", rq_err, e.err);
        if (e.rd && !e.err) chk(i == 0 ? "rdata0" : "rdata1", rdata, e.rdata);
      end
    end
  end
  task automatic issue(input int i, input bit rd, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [7:0] wd, input bit err, input logic [7:0] rdv);
    exp_t e;
    e.rd = rd;
    e.err = err;
    e.rdata = rdv;
    if (i == 0) begin
      rq_dev0 = dev; rq_reg0 = rg; rq_wdata0 = wd; exp_q0.push_back(e);
    end else begin
      rq_dev1 = dev; rq_reg1 = rg; rq_wdata1 = wd; exp_q1.push_back(e);
    end
    rq_rd[i] = rd;
    if (bus_chk) begin
      bus_exp.push_back({dev, 1'b0});
      bus_exp.push_back(rg);
      if (rd) begin
        bus_exp.push_back(STOP_TOK);
        bus_exp.push_back({dev, 1'b1});
      end else bus_exp.push_back(wd);
      bus_exp.push_back(STOP_TOK);
    end
    issue_n[i]++;
  endtask
  task automatic wait_done(input int lim);
    int n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("wait_done", n < lim, 1);
    repeat (3) @(negedge clk);
  endtask
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_ack"}, rq_ack, 0);
    chk({tag, "_done"}, rq_done, 0);
    chk({tag, "_err"}, rq_err, 0);
    chk({tag, "_rdata"}, rdata, 0);
    chk({tag, "_ena"}, m_ena, 0);
    chk({tag, "_rdwrt"}, m_rd_wrt, 0);
    chk({tag, "_addr"}, m_addr, 0);
    chk({tag, "_dwrt"}, m_data_wrt, 0);
    chk({tag, "_mrst"}, m_rst, 1);
  endtask
  initial begin
    int n, len;
    repeat (3) @(negedge clk);
    chk_reset_vals("rst");
    reset = 0;
    repeat (2) @(negedge clk);
    issue(0, 0, 7'h50, 8'h10, 8'hA5, 0, 0);
    wait_done(500);
    rd_val = 8'h3C;
    issue(1, 1, 7'h50, 8'h22, 8'h00, 0, 8'h3C);
    wait_done(500);
    for (int r = 0; r < 2; r++) begin
      rd_val = 8'h99;
      ack_exp.push_back(0);
      ack_exp.push_back(1);
      issue(0, 0, 7'h11, 8'h01, 8'h5A, 0, 0);
      issue(1, 1, 7'h12, 8'h02, 8'h00, 0, 8'h99);
      wait_done(800);
    end
    chk("ack_all_seen", ack_exp.size(), 0);
    bus_chk = 0;
    nack = 1;
    issue(1, 0, 7'h33, 8'h44, 8'h55, 1, 0);
    n = 0;
    while (!m_rst && n < 300) begin @(negedge clk); n++; end
    chk("nack_rst_seen", m_rst, 1);
    len = 0;
    while (m_rst && len < 10) begin @(negedge clk); len++; end
    chk("nack_rst_len", len, 2);
    wait_done(300);
    nack = 0;
    bus_exp.delete();
    bus_chk = 1;
    issue(0, 0, 7'h2A, 8'h3B, 8'h4C, 0, 0);
    wait_done(500);
    chk("bus_left", bus_exp.size(), 0);
    bus_chk = 0;
    hang = 1;
    issue(0, 0, 7'h40, 8'h01, 8'h02, 1, 0);
    n = 0;
    while (!m_rst && n < 2000) begin @(negedge clk); n++; end
    chk("hang_rst_seen", m_rst, 1);
    @(negedge clk);
    chk("timeout_cycles", rst_t - busy_t, TIMEOUT_CYC + 1);
    hang = 0;
    wait_done(300);
    issue(0, 0, 7'h21, 8'h31, 8'h77, 0, 0);
    n = 0;
    while (!(m_ena && m_data_wrt == 8'h77) && n < 300) begin @(negedge clk); n++; end
    chk("reached_data", m_ena && m_data_wrt == 8'h77, 1);
    reset = 1;
    exp_q0.delete();
    @(negedge clk);
    chk_reset_vals("midrst");
    repeat (3) @(negedge clk);
    reset = 0;
    n = 0;
    repeat (STOP_CYC * 3) begin
      @(negedge clk);
      n += rq_done != 0 || m_ena;
    end
    chk("post_reset_quiet", n, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
